// File: rtl/wr_fifo_interface_pkg.sv
// Shared constants for the write-FIFO unpacker: byte width, FSM encodings,
// and the elaboration-time helpers used to size the data field and index.
package wr_fifo_interface_pkg;

    localparam int BYTE_WIDTH = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    function automatic int ceil_division(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Bits needed to index 'value' entries; never less than one bit.
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/wr_byte_mux.sv
// Selects one byte of the buffered data word, index 0 being the most significant byte.
// Latency: purely combinational.
// Backpressure: none; the index is held upstream while the consumer stalls.
module wr_byte_mux
    import wr_fifo_interface_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_BYTES  = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [IDX_WIDTH-1:0]    index,
    output logic [BYTE_WIDTH-1:0]   byte_dat
);

    localparam int PAD_WIDTH = NUM_BYTES * BYTE_WIDTH;

    logic [PAD_WIDTH-1:0] padded;

    // A data field that is not a whole number of bytes is zero-filled at the bottom.
    always_comb begin
        padded = '0;
        padded[PAD_WIDTH-1 -: DATA_WIDTH] = data;
    end

    always_comb begin
        byte_dat = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (index == i[IDX_WIDTH-1:0]) begin
                byte_dat = padded[(NUM_BYTES-1-i)*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/wr_fifo_interface.sv
// Pops tagged words from the write FIFO and presents them to the controller byte by byte, MSB first.
// Latency: first byte two cycles after the read pulse; 16 bytes every 17 cycles when streaming.
// Backpressure: i_ctrl_re low holds the current byte; i_ctrl_abort drops the rest of the word.
module wr_fifo_interface
    import wr_fifo_interface_pkg::*;
#(
    parameter int WR_FIFO_DATA_WIDTH = 136,
    parameter int TAG_WIDTH          = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [WR_FIFO_DATA_WIDTH-1:0]   i_wr_fifo_data,
    input  logic                            i_wr_fifo_empty,
    output logic                            o_wr_fifo_re,
    output logic [7:0]                      o_ctrl_data,
    output logic [TAG_WIDTH-1:0]            o_ctrl_tag,
    output logic                            o_ctrl_valid,
    output logic                            o_ctrl_last,
    input  logic                            i_ctrl_re,
    input  logic                            i_ctrl_abort
);

    localparam int JUST_DATA_WIDTH = WR_FIFO_DATA_WIDTH - TAG_WIDTH;
    localparam int NUM_OF_BYTES    = ceil_division(JUST_DATA_WIDTH, BYTE_WIDTH);
    localparam int IDX_WIDTH       = log2(NUM_OF_BYTES);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OF_BYTES - 1);

    logic [1:0]                 state_q;
    logic [1:0]                 state_d;
    logic [IDX_WIDTH-1:0]       idx_q;
    logic [IDX_WIDTH-1:0]       idx_d;
    logic [JUST_DATA_WIDTH-1:0] data_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic                       load_word;
    logic                       fifo_re;
    logic                       is_last;
    logic                       ctrl_vld;
    logic [BYTE_WIDTH-1:0]      mux_dat;

    assign is_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fifo_re   = 1'b0;
        load_word = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!i_wr_fifo_empty) begin
                    fifo_re = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_ctrl_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    load_word = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                // Abort outranks consumption so a dropped word never triggers a new read.
                if (i_ctrl_abort) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (i_ctrl_re) begin
                    if (is_last) begin
                        idx_d = '0;
                        if (!i_wr_fifo_empty) begin
                            fifo_re = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_word) begin
                data_q <= i_wr_fifo_data[JUST_DATA_WIDTH-1:0];
                tag_q  <= i_wr_fifo_data[WR_FIFO_DATA_WIDTH-1 -: TAG_WIDTH];
            end
        end
    end

    wr_byte_mux #(
        .DATA_WIDTH (JUST_DATA_WIDTH),
        .NUM_BYTES  (NUM_OF_BYTES),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_byte_mux (
        .data       (data_q),
        .index      (idx_q),
        .byte_dat   (mux_dat)
    );

    // Outputs are gated by reset so nothing leaks out, and no FIFO read fires, in the reset cycle.
    assign ctrl_vld     = i_rst_n && (state_q == ST_OUTPUT);
    assign o_wr_fifo_re = i_rst_n && fifo_re;
    assign o_ctrl_valid = ctrl_vld;
    assign o_ctrl_last  = ctrl_vld && is_last;
    assign o_ctrl_data  = ctrl_vld ? mux_dat : 8'h00;
    assign o_ctrl_tag   = ctrl_vld ? tag_q : '0;

endmodule

// File: doc/wr_fifo_interface.md
WR_FIFO_INTERFACE -- requirements
Module: wr_fifo_interface

Interface
REQ-001 SHALL have parameter WR_FIFO_DATA_WIDTH, default 136: width of one Write FIFO word.
REQ-002 SHALL have parameter TAG_WIDTH, default 8: width of the per-word tag in the word MSBs.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port i_wr_fifo_data, input, WR_FIFO_DATA_WIDTH: Write FIFO read data, valid the cycle after o_wr_fifo_re.
REQ-006 SHALL have port i_wr_fifo_empty, input, 1: Write FIFO has no word.
REQ-007 SHALL have port o_wr_fifo_re, output, 1: Write FIFO read enable, one-cycle pulse per word.
REQ-008 SHALL have port o_ctrl_data, output, 8: current byte to the controller.
REQ-009 SHALL have port o_ctrl_tag, output, TAG_WIDTH: tag of the word being unpacked.
REQ-010 SHALL have port o_ctrl_valid, output, 1: o_ctrl_data/o_ctrl_tag valid.
REQ-011 SHALL have port o_ctrl_last, output, 1: current byte is the final byte of the word.
REQ-012 SHALL have port i_ctrl_re, input, 1: controller consumes the current byte this cycle.
REQ-013 SHALL have port i_ctrl_abort, input, 1: discard the rest of the current word.

Function
REQ-014 Data field SHALL be JUST_DATA_WIDTH = WR_FIFO_DATA_WIDTH-TAG_WIDTH (128); NUM_OF_BYTES = ceil(JUST_DATA_WIDTH/8) (16); tag = word[135:128].
REQ-015 Byte order SHALL be MSB first: index 0 = data[127:120], index 15 = data[7:0] (inverse of read-side packing).
REQ-016 SHALL implement states IDLE, FETCH, OUTPUT; reset state IDLE.
REQ-017 IDLE: o_wr_fifo_re = !i_wr_fifo_empty (combinational); if asserted, next state FETCH.
REQ-018 FETCH: SHALL register i_wr_fifo_data into data/tag buffers, index <= 0, next state OUTPUT; o_ctrl_valid = 0.
REQ-019 OUTPUT: o_ctrl_valid = 1, o_ctrl_data = byte[index], o_ctrl_last = (index == NUM_OF_BYTES-1).
REQ-020 OUTPUT with i_ctrl_re and not last: index <= index+1, stay OUTPUT.
REQ-021 OUTPUT with i_ctrl_re on last byte: if !i_wr_fifo_empty, assert o_wr_fifo_re same cycle and go FETCH (one-cycle bubble between words); else go IDLE.
REQ-022 OUTPUT with i_ctrl_re deasserted: hold index, data, valid (no byte lost or repeated).
REQ-023 i_ctrl_abort in OUTPUT SHALL take priority over i_ctrl_re: index <= 0, next IDLE, no o_wr_fifo_re that cycle.
REQ-024 i_ctrl_abort in FETCH SHALL discard the arriving word, next IDLE; ignored in IDLE.
REQ-025 o_wr_fifo_re SHALL never assert while i_wr_fifo_empty = 1 nor in FETCH.
REQ-026 i_ctrl_re SHALL be ignored when o_ctrl_valid = 0.
REQ-027 Throughput SHALL be 16 bytes per 17 cycles with FIFO non-empty and i_ctrl_re held high.

Reset
REQ-028 With i_rst_n low at a clock edge: state IDLE, index 0, data and tag buffers 0.
REQ-029 During and after reset: o_wr_fifo_re 0, o_ctrl_valid 0, o_ctrl_last 0, o_ctrl_data 0, o_ctrl_tag 0.
REQ-030 Reset mid-word SHALL discard the partial word; no FIFO read in the reset cycle.

Structure
REQ-031 JUST_DATA_WIDTH, NUM_OF_BYTES and state encodings SHALL live in the shared flash-controller defines include; log2/ceil_division come from the shared functions include.
REQ-032 Index width SHALL be log2(NUM_OF_BYTES) bits.
REQ-033 The byte selector SHALL be one sub-module, wr_byte_mux (buffer + index -> 8-bit byte, purely combinational).

Verification
REQ-034 Word tag 0xA5, data 0x00112233_44556677_8899AABB_CCDDEEFF, i_ctrl_re high -> bytes 0x00..0xFF in order, tag 0xA5, o_ctrl_last only on 0xFF.
REQ-035 Two words queued, i_ctrl_re high -> re pulses 17 cycles apart, exactly one valid-low bubble between words.
REQ-036 i_ctrl_re toggled 1/0 each cycle -> each byte presented until consumed, 16 bytes total, no duplicates.
REQ-037 i_ctrl_abort at index 5 with a second word queued -> valid drops, IDLE, next word starts at byte 0 with its own tag.
REQ-038 i_rst_n low at index 9 -> all outputs 0 next cycle, no re during reset, after release next FIFO word unpacked from byte 0.
REQ-039 FIFO empty for 20 cycles -> o_wr_fifo_re and o_ctrl_valid stay 0 throughout.
